// File: rtl/wb_burst_sram_ctrl.sv
// Wishbone B3 burst slave driving a single-port synchronous SRAM; reads stream one beat per clock.
// Define WB_BURST_SRAM_CTRL_RANGE_CHECK_EN to answer out-of-range first beats with wb_err_o.
module wb_burst_sram_ctrl #(
   parameter int AW     = 32,
   parameter int MEM_AW = 25
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic [AW-1:0]     wb_adr_i,
   input  logic [31:0]       wb_dat_i,
   input  logic [3:0]        wb_sel_i,
   input  logic              wb_we_i,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic [2:0]        wb_cti_i,
   input  logic [1:0]        wb_bte_i,
   output logic [31:0]       wb_dat_o,
   output logic              wb_ack_o,
   output logic              wb_err_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [MEM_AW-1:0] mem_addr_o,
   output logic [3:0]        mem_be_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
`ifdef WB_BURST_SRAM_CTRL_RANGE_CHECK_EN
   localparam logic [1:0] ST_ERR    = 2'd2;
`endif

   logic [1:0]        state_q, state_d;
   logic [MEM_AW-1:0] addr_q, addr_d, step_addr, start_addr;
   logic [2:0]        cti_q;
   logic [1:0]        bte_q;
   logic              we_q;
   logic              req_valid, out_of_range, start, last_beat, ack;
   logic              mem_req, mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;

   assign start_addr = wb_adr_i[MEM_AW+1:2];
   assign req_valid  = wb_cyc_i & wb_stb_i;
   assign last_beat  = (wb_cti_i == 3'b000) || (wb_cti_i == 3'b111);
   assign start      = (state_q == ST_IDLE) && req_valid && !out_of_range;

`ifdef WB_BURST_SRAM_CTRL_RANGE_CHECK_EN
   logic unused_adr;
   assign unused_adr   = ^wb_adr_i[1:0];
   assign out_of_range = |wb_adr_i[AW-1:MEM_AW+2];
   assign wb_err_o     = (state_q == ST_ERR);
`else
   logic unused_adr;
   assign unused_adr   = ^{wb_adr_i[1:0], wb_adr_i[AW-1:MEM_AW+2]};
   assign out_of_range = 1'b0;
   assign wb_err_o     = 1'b0;
`endif

   // Wrapping bursts advance only the low 2/3/4 bits; constant-address bursts hold.
   always_comb begin
      step_addr = addr_q;
      if (cti_q != 3'b001) begin
         case (bte_q)
            2'b00:   step_addr = addr_q + 1'b1;
            2'b01:   step_addr = {addr_q[MEM_AW-1:2], addr_q[1:0] + 2'd1};
            2'b10:   step_addr = {addr_q[MEM_AW-1:3], addr_q[2:0] + 3'd1};
            default: step_addr = {addr_q[MEM_AW-1:4], addr_q[3:0] + 4'd1};
         endcase
      end
   end

   // A beat is accepted when ack and stb are high together in ACTIVE. ack is a pure
   // gate of cyc&stb, so dropping stb is a wait state and costs exactly one cycle.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      ack       = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_be    = '0;
      mem_wdata = '0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ACTIVE;
               addr_d  = start_addr;
               if (!wb_we_i) begin
                  mem_req  = 1'b1;
                  mem_addr = start_addr;
               end
            end
`ifdef WB_BURST_SRAM_CTRL_RANGE_CHECK_EN
            else if (req_valid) begin
               state_d = ST_ERR;
            end
`endif
         end
         ST_ACTIVE: begin
            if (!wb_cyc_i) begin
               state_d = ST_IDLE;
            end else begin
               ack = wb_stb_i;
               if (ack) begin
                  addr_d = step_addr;
                  if (last_beat) state_d = ST_IDLE;
               end
               if (we_q) begin
                  if (ack) begin
                     mem_req   = 1'b1;
                     mem_we    = 1'b1;
                     mem_addr  = addr_q;
                     mem_be    = wb_sel_i;
                     mem_wdata = wb_dat_i;
                  end
               end else begin
                  // Fetch one address ahead so the next beat's data is ready on arrival.
                  mem_req  = 1'b1;
                  mem_addr = ack ? step_addr : addr_q;
               end
            end
         end
`ifdef WB_BURST_SRAM_CTRL_RANGE_CHECK_EN
         ST_ERR:  state_d = ST_IDLE;
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         cti_q   <= 3'b000;
         bte_q   <= 2'b00;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         if (start) begin
            cti_q <= wb_cti_i;
            bte_q <= wb_bte_i;
            we_q  <= wb_we_i;
         end
      end
   end

   // The SRAM side is forced quiet while reset is held, even if the master keeps cyc/stb up.
   assign mem_req_o   = wb_rst_ni & mem_req;
   assign mem_we_o    = wb_rst_ni & mem_we;
   assign mem_addr_o  = wb_rst_ni ? mem_addr  : '0;
   assign mem_be_o    = wb_rst_ni ? mem_be    : '0;
   assign mem_wdata_o = wb_rst_ni ? mem_wdata : '0;
   assign wb_ack_o    = ack;
   assign wb_dat_o    = mem_rdata_i;

endmodule

// File: tb/tb_wb_burst_sram_ctrl.sv
// Directed bench for wb_burst_sram_ctrl: classic, linear/wrap bursts, wait states, error/alias, async reset.
module tb_wb_burst_sram_ctrl;

   localparam int AW     = 32;
   localparam int MEM_AW = 25;

   logic              clk;
   logic              rst_n;
   logic [AW-1:0]     adr;
   logic [31:0]       dat_w;
   logic [3:0]        sel;
   logic              we;
   logic              cyc;
   logic              stb;
   logic [2:0]        cti;
   logic [1:0]        bte;
   logic [31:0]       dat_r;
   logic              ack;
   logic              err;
   logic              mem_req;
   logic              mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   wb_burst_sram_ctrl #(.AW(AW), .MEM_AW(MEM_AW)) dut (
      .wb_clk_i    (clk),
      .wb_rst_ni   (rst_n),
      .wb_adr_i    (adr),
      .wb_dat_i    (dat_w),
      .wb_sel_i    (sel),
      .wb_we_i     (we),
      .wb_cyc_i    (cyc),
      .wb_stb_i    (stb),
      .wb_cti_i    (cti),
      .wb_bte_i    (bte),
      .wb_dat_o    (dat_r),
      .wb_ack_o    (ack),
      .wb_err_o    (err),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_be_o    (mem_be),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // SRAM model: requests are captured at negedge and acted on at the next posedge.
   logic [31:0]       sram [0:255];
   bit                loaded;
   logic              s_req, s_we;
   logic [MEM_AW-1:0] s_addr;
   logic [3:0]        s_be;
   logic [31:0]       s_wdata;
   logic [MEM_AW-1:0] req_log[$];

   function automatic logic [31:0] pat(input logic [MEM_AW-1:0] w);
      return 32'hA5A5_0000 | 32'(w);
   endfunction

   always @(negedge clk) begin
      s_req   = mem_req;
      s_we    = mem_we;
      s_addr  = mem_addr;
      s_be    = mem_be;
      s_wdata = mem_wdata;
      if (mem_req) req_log.push_back(mem_addr);
   end

   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 256; i++) sram[i] <= (i < 16) ? pat(MEM_AW'(i)) : 32'h0;
         loaded <= 1'b1;
      end else if (s_req) begin
         if (s_we) begin
            for (int b = 0; b < 4; b++)
               if (s_be[b]) sram[s_addr[7:0]][b*8 +: 8] <= s_wdata[b*8 +: 8];
         end else begin
            mem_rdata <= sram[s_addr[7:0]];
         end
      end
   end

   // scoreboard
   int                checks = 0;
   int                errors = 0;
   logic [MEM_AW-1:0] exp_q[$];
   logic [MEM_AW-1:0] exp_log[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_log(input string tag);
      check({tag, "_len"}, 32'(req_log.size()), 32'(exp_log.size()));
      for (int i = 0; i < exp_log.size(); i++)
         if (i < req_log.size()) check(tag, 32'(req_log[i]), 32'(exp_log[i]));
      exp_log.delete();
      req_log.delete();
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ack"},   32'(ack),       32'd0);
      check({tag, "_err"},   32'(err),       32'd0);
      check({tag, "_req"},   32'(mem_req),   32'd0);
      check({tag, "_we"},    32'(mem_we),    32'd0);
      check({tag, "_addr"},  32'(mem_addr),  32'd0);
      check({tag, "_be"},    32'(mem_be),    32'd0);
      check({tag, "_wdata"}, mem_wdata,      32'd0);
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0;
      dat_w = '0; sel = '0; cti = 3'b000; bte = 2'b00;
   endtask

   // Leaves the bus asserted at posedge+1 after the ack cycle.
   task automatic classic(input string tag, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          input logic [MEM_AW-1:0] exp_w, input logic [31:0] exp_d);
      cyc = 1'b1; stb = 1'b1; we = wr; adr = a; dat_w = d; sel = s;
      cti = 3'b000; bte = 2'b00;
      @(negedge clk);
      check({tag, "_c0_ack"}, 32'(ack), 32'd0);
      check({tag, "_c0_req"}, 32'(mem_req), 32'(!wr));
      if (!wr) check({tag, "_c0_addr"}, 32'(mem_addr), 32'(exp_w));
      tick();
      @(negedge clk);
      check({tag, "_c1_ack"}, 32'(ack), 32'd1);
      check({tag, "_c1_err"}, 32'(err), 32'd0);
      if (wr) begin
         check({tag, "_req"},   32'(mem_req),  32'd1);
         check({tag, "_we"},    32'(mem_we),   32'd1);
         check({tag, "_addr"},  32'(mem_addr), 32'(exp_w));
         check({tag, "_be"},    32'(mem_be),   32'(s));
         check({tag, "_wdata"}, mem_wdata,     d);
      end else begin
         check({tag, "_data"}, dat_r, exp_d);
      end
      tick();
   endtask

   // Burst of n beats; beat addresses come from exp_q. stb drops for gap_len cycles after
   // gap_at beats. Leaves the bus asserted at posedge+1 after the last ack.
   task automatic run_burst(input string tag, input logic wr, input logic [31:0] a, input int n,
                            input logic [1:0] b, input int gap_at, input int gap_len);
      int k;
      int gap_left;
      logic [MEM_AW-1:0] w;
      k = 0;
      gap_left = 0;
      req_log.delete();
      cyc = 1'b1; stb = 1'b1; we = wr; adr = a; cti = 3'b010; bte = b;
      sel = 4'hf; dat_w = 32'hC0DE_0000;
      @(negedge clk);
      check({tag, "_first_ack"}, 32'(ack), 32'd0);
      while (k < n) begin
         tick();
         if (gap_left > 0) begin
            stb = 1'b0;
            gap_left--;
         end else begin
            stb   = 1'b1;
            cti   = (k == n - 1) ? 3'b111 : 3'b010;
            dat_w = 32'hC0DE_0000 + 32'(k);
         end
         @(negedge clk);
         if (!stb) begin
            check({tag, "_gap_ack"}, 32'(ack), 32'd0);
         end else begin
            check({tag, "_ack"}, 32'(ack), 32'd1);
            check({tag, "_err"}, 32'(err), 32'd0);
            w = exp_q.pop_front();
            if (wr) begin
               check({tag, "_req"},   32'(mem_req),  32'd1);
               check({tag, "_we"},    32'(mem_we),   32'd1);
               check({tag, "_addr"},  32'(mem_addr), 32'(w));
               check({tag, "_wdata"}, mem_wdata,     32'hC0DE_0000 + 32'(k));
            end else begin
               check({tag, "_data"}, dat_r, pat(w));
            end
            k++;
            if (k == gap_at) gap_left = gap_len;
         end
      end
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      check_quiet("reset");
      rst_n = 1'b1;
      tick();

      classic("cl_wr", 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011, 25'h40, 32'h0);
      idle(); tick();
      classic("cl_rd", 1'b0, 32'h100, 32'h0, 4'hf, 25'h40, 32'h0000_BEEF);
      idle(); tick();

      // linear read of 8, then a back-to-back classic read proves the FSM returned to IDLE
      for (int i = 0; i < 8; i++) exp_q.push_back(MEM_AW'(i));
      run_burst("lin8", 1'b0, 32'h0, 8, 2'b00, 0, 0);
      for (int i = 0; i < 9; i++) exp_log.push_back(MEM_AW'(i));
      check_log("lin8_addr");
      classic("b2b_rd", 1'b0, 32'h100, 32'h0, 4'hf, 25'h40, 32'h0000_BEEF);
      idle(); tick();

      exp_q.push_back(25'd6); exp_q.push_back(25'd7); exp_q.push_back(25'd4); exp_q.push_back(25'd5);
      run_burst("wrap4_rd", 1'b0, 32'h18, 4, 2'b01, 0, 0);
      exp_log.push_back(25'd6); exp_log.push_back(25'd7); exp_log.push_back(25'd4);
      exp_log.push_back(25'd5); exp_log.push_back(25'd6);
      check_log("wrap4_rd_addr");
      idle(); tick();

      exp_q.push_back(25'd6); exp_q.push_back(25'd7); exp_q.push_back(25'd4); exp_q.push_back(25'd5);
      run_burst("wrap4_wr", 1'b1, 32'h18, 4, 2'b01, 0, 0);
      exp_log.push_back(25'd6); exp_log.push_back(25'd7);
      exp_log.push_back(25'd4); exp_log.push_back(25'd5);
      check_log("wrap4_wr_addr");
      idle(); tick();
      check("wrap4_mem6", sram[6], 32'hC0DE_0000);
      check("wrap4_mem7", sram[7], 32'hC0DE_0001);
      check("wrap4_mem4", sram[4], 32'hC0DE_0002);
      check("wrap4_mem5", sram[5], 32'hC0DE_0003);

      // stb low for 2 cycles after beat 2: prefetch re-issues word 10 during the gap
      for (int i = 8; i < 13; i++) exp_q.push_back(MEM_AW'(i));
      run_burst("gap_rd", 1'b0, 32'h20, 5, 2'b00, 2, 2);
      exp_log.push_back(25'd8);  exp_log.push_back(25'd9);  exp_log.push_back(25'd10);
      exp_log.push_back(25'd10); exp_log.push_back(25'd10); exp_log.push_back(25'd11);
      exp_log.push_back(25'd12); exp_log.push_back(25'd13);
      check_log("gap_rd_addr");
      idle(); tick();

`ifdef WB_BURST_SRAM_CTRL_RANGE_CHECK_EN
      req_log.delete();
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h2000_0000; cti = 3'b000; bte = 2'b00;
      @(negedge clk);
      check("oor_c0_err", 32'(err), 32'd0);
      check("oor_c0_ack", 32'(ack), 32'd0);
      tick();
      @(negedge clk);
      check("oor_c1_err", 32'(err), 32'd1);
      check("oor_c1_ack", 32'(ack), 32'd0);
      tick();
      idle();
      @(negedge clk);
      check("oor_c2_err", 32'(err), 32'd0);
      tick();
      check("oor_no_req", 32'(req_log.size()), 32'd0);
`else
      classic("alias_rd", 1'b0, 32'h2000_0000, 32'h0, 4'hf, 25'h0, pat(25'd0));
      idle(); tick();
`endif

      // asynchronous reset in the middle of a read burst
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; cti = 3'b010; bte = 2'b00;
      @(negedge clk);
      tick();
      @(negedge clk);
      check("rst_b0_ack", 32'(ack), 32'd1);
      tick();
      @(negedge clk);
      check("rst_b1_ack", 32'(ack), 32'd1);
      check("rst_b1_data", dat_r, pat(25'd1));
      #2;
      rst_n = 1'b0;
      #1;
      check_quiet("rst_mid");
      tick();
      idle();
      tick();
      rst_n = 1'b1;
      tick();
      classic("post_rst_rd", 1'b0, 32'h100, 32'h0, 4'hf, 25'h40, 32'h0000_BEEF);
      idle(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
